// File: rtl/drive_arbiter.sv
// Drive arbiter: selects the motion owner (obstacle, manual, tape tracking), sequences
// direction reversals through a zero-drive dead time and generates per-wheel PWM.
module drive_arbiter #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_FULL   = 230,
    parameter int DUTY_SLOW   = 128,
    parameter int DUTY_REV    = 160,
    parameter int DEAD_CYCLES = 25_000,
    parameter int HOLD_CYCLES = 1_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] trk_dir,
    input  logic       obs_stop,
    input  logic       man_req,
    input  logic [3:0] man_dir,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [1:0] grant,
    output logic [3:0] active_cmd,
    output logic       busy
);

    localparam logic [3:0] CMD_FWD    = 4'b0000;
    localparam logic [3:0] CMD_VEER_L = 4'b0101;
    localparam logic [3:0] CMD_VEER_R = 4'b1001;
    localparam logic [3:0] CMD_REV    = 4'b0011;
    localparam logic [3:0] CMD_STOP   = 4'b1111;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_TRK  = 2'b01;
    localparam logic [1:0] SRC_MAN  = 2'b10;
    localparam logic [1:0] SRC_OBS  = 2'b11;

    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [PWM_BITS-1:0]   PWM_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0]   PWM_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0]   PWM_MAX   = {PWM_BITS{1'b1}};
    localparam logic [DEAD_W-1:0]     DEAD_ZERO = {DEAD_W{1'b0}};
    localparam logic [DEAD_W-1:0]     DEAD_ONE  = {{(DEAD_W-1){1'b0}}, 1'b1};
    localparam logic [DEAD_W-1:0]     DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]     HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0]     HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_STOP = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    function automatic logic [3:0] norm_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_FWD, CMD_VEER_L, CMD_VEER_R, CMD_REV, CMD_STOP: norm_cmd = cmd;
            default:                                            norm_cmd = CMD_STOP;
        endcase
    endfunction

    // Packed {left, right} duty for a normalised command.
    function automatic logic [2*PWM_BITS-1:0] cmd_duty(input logic [3:0] cmd);
        case (cmd)
            CMD_FWD:    cmd_duty = {PWM_BITS'(DUTY_FULL), PWM_BITS'(DUTY_FULL)};
            CMD_VEER_L: cmd_duty = {PWM_BITS'(DUTY_SLOW), PWM_BITS'(DUTY_FULL)};
            CMD_VEER_R: cmd_duty = {PWM_BITS'(DUTY_FULL), PWM_BITS'(DUTY_SLOW)};
            CMD_REV:    cmd_duty = {PWM_BITS'(DUTY_REV),  PWM_BITS'(DUTY_REV)};
            default:    cmd_duty = {PWM_ZERO, PWM_ZERO};
        endcase
    endfunction

    state_t                state_r, state_nx_s;
    logic [PWM_BITS-1:0]   pwm_cnt_r, duty_l_r, duty_r_r;
    logic [DEAD_W-1:0]     dead_cnt_r;
    logic [HOLD_W-1:0]     hold_cnt_r;
    logic                  pwm_l_r, pwm_r_r, dir_l_r, dir_r_r, busy_r;
    logic [1:0]            grant_r;
    logic [3:0]            active_cmd_r;

    logic [3:0]            req_cmd_s;
    logic [1:0]            req_src_s;
    logic                  differ_s, blocked_s, accept_s;
    logic                  req_stop_s, req_fwd_s, flip_s, act_fwd_s, wrap_s;
    logic                  enter_dead_s, exit_dead_s, zero_now_s;
    logic [2*PWM_BITS-1:0] act_duty_s;

    // Fixed-priority request selection.
    always_comb begin
        req_cmd_s = CMD_STOP;
        req_src_s = SRC_OBS;
        if (obs_stop) begin
            req_cmd_s = CMD_STOP;
            req_src_s = SRC_OBS;
        end else if (man_req) begin
            req_cmd_s = norm_cmd(man_dir);
            req_src_s = SRC_MAN;
        end else begin
            req_cmd_s = norm_cmd(trk_dir);
            req_src_s = SRC_TRK;
        end
    end

    assign differ_s   = (req_cmd_s != active_cmd_r) || (req_src_s != grant_r);
    assign blocked_s  = ((state_r == S_DEAD) && (req_src_s != SRC_OBS)) ||
                        ((req_src_s == SRC_TRK) && (hold_cnt_r != HOLD_ZERO));
    assign accept_s   = differ_s && !blocked_s;
    assign req_stop_s = (req_cmd_s == CMD_STOP);
    assign req_fwd_s  = (req_cmd_s != CMD_REV);
    assign flip_s     = !req_stop_s && ((dir_l_r != req_fwd_s) || (dir_r_r != req_fwd_s));
    assign act_fwd_s  = (active_cmd_r != CMD_REV);
    assign act_duty_s = cmd_duty(active_cmd_r);
    assign wrap_s     = (pwm_cnt_r == PWM_MAX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_STOP;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state plus the strobes that steer the datapath.
    always_comb begin
        state_nx_s   = state_r;
        enter_dead_s = 1'b0;
        exit_dead_s  = 1'b0;
        zero_now_s   = 1'b0;
        case (state_r)
            S_STOP, S_RUN: begin
                if (!accept_s) begin
                    state_nx_s = state_r;
                end else if (req_stop_s) begin
                    state_nx_s = S_STOP;
                    zero_now_s = 1'b1;
                end else if (flip_s) begin
                    state_nx_s   = S_DEAD;
                    enter_dead_s = 1'b1;
                    zero_now_s   = 1'b1;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_DEAD: begin
                // Only the obstacle source can be accepted here, and it always means STOP.
                if (accept_s) begin
                    state_nx_s = S_STOP;
                    zero_now_s = 1'b1;
                end else if (dead_cnt_r == DEAD_ZERO) begin
                    state_nx_s  = S_RUN;
                    exit_dead_s = 1'b1;
                end else begin
                    state_nx_s = S_DEAD;
                end
            end
            default: begin
                state_nx_s = S_STOP;
                zero_now_s = 1'b1;
            end
        endcase
    end

    // Ownership, hold timer, dead-time counter and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r      <= SRC_NONE;
            active_cmd_r <= CMD_STOP;
            hold_cnt_r   <= HOLD_ZERO;
            dead_cnt_r   <= DEAD_ZERO;
            busy_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                grant_r      <= req_src_s;
                active_cmd_r <= req_cmd_s;
                hold_cnt_r   <= (req_src_s == SRC_TRK) ? HOLD_LOAD : HOLD_ZERO;
            end else if (hold_cnt_r != HOLD_ZERO) begin
                hold_cnt_r <= hold_cnt_r - HOLD_ONE;
            end
            if (enter_dead_s) begin
                dead_cnt_r <= DEAD_LOAD;
            end else if ((state_r == S_DEAD) && (dead_cnt_r != DEAD_ZERO)) begin
                dead_cnt_r <= dead_cnt_r - DEAD_ONE;
            end else begin
                dead_cnt_r <= DEAD_ZERO;
            end
            busy_r <= (state_nx_s == S_DEAD);
        end
    end

    // PWM counter, duties (loaded only at wrap or dead-time exit) and wheel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= PWM_ZERO;
            duty_l_r  <= PWM_ZERO;
            duty_r_r  <= PWM_ZERO;
            pwm_l_r   <= 1'b0;
            pwm_r_r   <= 1'b0;
            dir_l_r   <= 1'b1;
            dir_r_r   <= 1'b1;
        end else begin
            pwm_cnt_r <= exit_dead_s ? PWM_ZERO : (pwm_cnt_r + PWM_ONE);
            if (zero_now_s) begin
                duty_l_r <= PWM_ZERO;
                duty_r_r <= PWM_ZERO;
            end else if (exit_dead_s || ((state_r == S_RUN) && wrap_s)) begin
                {duty_l_r, duty_r_r} <= act_duty_s;
            end
            if (zero_now_s) begin
                pwm_l_r <= 1'b0;
                pwm_r_r <= 1'b0;
            end else begin
                pwm_l_r <= (pwm_cnt_r < duty_l_r);
                pwm_r_r <= (pwm_cnt_r < duty_r_r);
            end
            if (exit_dead_s) begin
                dir_l_r <= act_fwd_s;
                dir_r_r <= act_fwd_s;
            end
        end
    end

    assign pwm_l      = pwm_l_r;
    assign pwm_r      = pwm_r_r;
    assign dir_l      = dir_l_r;
    assign dir_r      = dir_r_r;
    assign grant      = grant_r;
    assign active_cmd = active_cmd_r;
    assign busy       = busy_r;

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Sits between the debounced magnetic-tape steering block and the two wheel drivers.
- Arbitrates motion requests from three sources, in priority order: obstacle stop, manual override, tape tracking.
- Sequences direction reversals with a dead time and rate-limits tracking-driven changes with a hold timer.
- Generates per-wheel PWM and direction outputs.

Parameters:
PWM_BITS, 8, width of PWM counter and duty values; PWM period = 2^PWM_BITS clk cycles
DUTY_FULL, 230, duty for full-speed wheel
DUTY_SLOW, 128, duty for inside wheel while veering
DUTY_REV, 160, duty for both wheels in reverse
DEAD_CYCLES, 25_000, zero-drive cycles before any direction flip (1 ms at 25 MHz)
HOLD_CYCLES, 1_250_000, minimum cycles between accepted tracking-sourced changes (50 ms)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
trk_dir  in  4  tracking command from tape-sensor block
obs_stop  in  1  obstacle stop request, level
man_req  in  1  manual override request, level
man_dir  in  4  manual command
pwm_l  out  1  left wheel PWM
pwm_r  out  1  right wheel PWM
dir_l  out  1  left wheel direction, 1 = forward
dir_r  out  1  right wheel direction, 1 = forward
grant  out  2  current owner: 00 none, 01 track, 10 manual, 11 obstacle
active_cmd  out  4  command currently applied
busy  out  1  high while in dead time

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Command codes and wheel duties (duty_l / duty_r):
  - 0000 FWD: FULL / FULL
  - 0101 VEER_L: SLOW / FULL
  - 1001 VEER_R: FULL / SLOW
  - 1111 STOP: 0 / 0
  - 0011 REV: REV / REV, dir bits 0
  - Any other code is treated as 1111.
  - Non-REV codes require dir bits 1. STOP requires no direction; it leaves dir bits unchanged.
- Reset (async, all registered outputs):
  - pwm_l=pwm_r=0, dir_l=dir_r=1, grant=00, active_cmd=1111, busy=0.
  - Duty registers, PWM counter, dead counter and hold counter cleared; state=S_STOP.
  - Reset asserted mid-operation aborts any dead time or hold immediately.
- Request selection (combinational, each cycle):
  - obs_stop → (1111, 11)
  - else man_req → (man_dir, 10)
  - else → (trk_dir, 01)
- Acceptance: a request is accepted when its code differs from active_cmd or its source differs from grant, and none of these block it:
  - state is S_DEAD, unless source is 11;
  - source is 01 and hold_cnt != 0.
  - Blocked requests are dropped, not queued.
- On accept with a tracking source: hold_cnt loads HOLD_CYCLES and decrements to 0. An accept from source 10 or 11 clears hold_cnt.
- States:
  - S_STOP: duties 0. Accept of a non-STOP code goes to S_RUN, or to S_DEAD if a direction flip is required.
  - S_RUN: accept without flip goes to S_RUN; accept with flip goes to S_DEAD; accept of STOP goes to S_STOP.
  - S_DEAD:
    - busy=1, duties forced 0 from the next edge, dir unchanged, grant/active_cmd already show the pending request.
    - Counts DEAD_CYCLES, then on the following edge updates dir bits, loads duties, clears the PWM counter and enters S_RUN with busy=0.
    - obs_stop during S_DEAD aborts: next edge goes to S_STOP, busy=0, dir unchanged.
- Flip required = required dir bits differ from current dir_l/dir_r.
- Latency and PWM:
  - grant/active_cmd update on the edge after the request is sampled.
  - Duty for a non-flip change is loaded at the next PWM counter wrap (glitch-free).
  - Exception: STOP, whatever its source, zeroes duties and drives pwm low on the next edge.
  - pwm_x = (pwm_cnt < duty_x), registered; pwm_cnt free-runs and wraps 2^PWM_BITS-1 → 0.
  - Duty 0 gives a constant low output.
- Simultaneous events: obs_stop always wins. man_req deasserting returns ownership to tracking on the next edge, with hold_cnt cleared.

Test Plan:
Bench parameters for all scenarios: PWM_BITS=4, DUTY_FULL=12, DUTY_SLOW=6, DUTY_REV=8, DEAD_CYCLES=4, HOLD_CYCLES=8.
1. Release reset, trk_dir=0000 → grant=01, active_cmd=0000 next edge; after the next wrap, pwm_l and pwm_r are high 12 of every 16 cycles; dir=11.
2. Running FWD, trk_dir→0101 three cycles after accept → ignored until hold_cnt=0; then active_cmd=0101 and, after the wrap, pwm_l high 6 of 16 and pwm_r high 12 of 16.
3. Running FWD, man_req=1 with man_dir=0011 → grant=10, busy=1 for 4 cycles with pwm low, then dir_l=dir_r=0, busy=0, pwm high 8 of 16.
4. obs_stop asserted during S_DEAD → next edge grant=11, active_cmd=1111, busy=0, pwm low, dir unchanged; after deassert, tracking re-acquires with grant=01.
5. man_req=1 with man_dir=0110 → active_cmd=1111, pwm low next edge.
6. Assert rst mid-S_DEAD → outputs immediately pwm=0, dir=11, grant=00, active_cmd=1111, busy=0.
